// File: rtl/compare_pkg.sv
// Shared types for serial_compare: operation encodings, FSM states and the
// function that turns first-difference flags into a compare outcome.
package compare_pkg;

  typedef enum logic [1:0] {
    OP_LT = 2'b00,
    OP_LE = 2'b01,
    OP_EQ = 2'b10,
    OP_NE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // lt/gt record which operand was smaller at the most significant differing slice.
  function automatic logic op_result(input op_e op, input logic lt, input logic gt);
    logic res;
    case (op)
      OP_LT:   res = lt;
      OP_LE:   res = !gt;
      OP_EQ:   res = !lt && !gt;
      default: res = lt || gt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module compare_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_compare.sv
// Multi-cycle magnitude/equality comparator, one CHUNK-bit slice per cycle, MSB first.
// Define SERIAL_COMPARE_EARLY_EXIT_EN to finish at the first differing slice.
module serial_compare
  import compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic             result
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic [IDX_W-1:0] idx_q;
  logic             lt_q, gt_q;
  logic             result_q;

  logic             accept;
  logic             last;
  logic             slice_lt, slice_eq;
  logic             first_diff;
  logic             lt_next, gt_next;

  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b  (b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .lt (slice_lt),
    .eq (slice_eq)
  );

  // Flags only latch at the most significant differing slice; later slices are ignored.
  assign first_diff = !lt_q && !gt_q;
  assign lt_next    = lt_q || (first_diff && slice_lt);
  assign gt_next    = gt_q || (first_diff && !slice_lt && !slice_eq);

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  assign last = (idx_q == '0) || (first_diff && !slice_eq);
`else
  assign last = (idx_q == '0);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_LT;
      idx_q    <= '0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      result_q <= 1'b0;
    end else if (accept) begin
      // Flipping both sign bits maps two's-complement order onto unsigned order.
      a_q   <= a ^ (MSB_MASK & {WIDTH{sgn}});
      b_q   <= b ^ (MSB_MASK & {WIDTH{sgn}});
      op_q  <= op_e'(op);
      idx_q <= IDX_W'(N - 1);
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else if (state_q == RUN) begin
      lt_q  <= lt_next;
      gt_q  <= gt_next;
      idx_q <= idx_q - IDX_W'(1);
      if (last) result_q <= op_result(op_q, lt_next, gt_next);
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_serial_compare.sv
// Self-checking bench for serial_compare: directed cases, start-ignore, back-to-back,
// mid-run reset and randomised transactions against a plain-arithmetic reference.
module tb_serial_compare;

  parameter int WIDTH = 32;
  parameter int CHUNK = 4;
  localparam int N = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = 2'b00;
  logic             sgn = 1'b0;
  logic             busy, done, result;

  int total = 0;
  int bad   = 0;

  serial_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .sgn    (sgn),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  function automatic logic ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [1:0] o, input logic s);
    logic less, same;
    less = s ? ($signed(x) < $signed(y)) : (x < y);
    same = (x == y);
    case (o)
      2'b00:   return less;
      2'b01:   return less || same;
      2'b10:   return same;
      default: return !same;
    endcase
  endfunction

  // Cycles from accept to done: N, or with early exit the 1-based slice holding
  // the highest differing bit.
  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int p;
    if (x == y) return N;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    p = 0;
    for (int i = 0; i < WIDTH; i++) if (x[i] != y[i]) p = i;
    return (WIDTH - 1 - p) / CHUNK + 1;
`else
    return N;
`endif
  endfunction

  // Issue one compare from idle/done, scramble the inputs after accept, wait for done.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [1:0] top, input logic tsgn,
                       output logic res, output int lat, output logic busy_at_done);
    @(negedge clk);
    a = ta; b = tb_v; op = top; sgn = tsgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rand_word(); b = rand_word();
    op = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
    lat = -1; res = 1'bx; busy_at_done = 1'bx;
    for (int c = 1; c <= N + 3; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = c; res = result; busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 1'b0) begin bad++; $display("FAIL reset_result got=%b want=0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  o;
    logic        s;
    logic        want;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[8];
    logic res, bz;
    int   lat;
    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 2'b00, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0007, 32'h0000_0007, 2'b01, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0007, 32'h0000_0007, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1};
    vecs[6] = '{32'hDEAD_BEEF, 32'hDEAD_BEEE, 2'b11, 1'b0, 1'b1};
    vecs[7] = '{32'h1000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b1};
    foreach (vecs[i]) begin
      issue(WIDTH'(vecs[i].x), WIDTH'(vecs[i].y), vecs[i].o, vecs[i].s, res, lat, bz);
      total++;
      if (res !== vecs[i].want) begin
        bad++; $display("FAIL directed_%0d_result got=%b want=%b", i, res, vecs[i].want);
      end
      total++;
      if (lat !== exp_lat(WIDTH'(vecs[i].x), WIDTH'(vecs[i].y))) begin
        bad++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat,
                        exp_lat(WIDTH'(vecs[i].x), WIDTH'(vecs[i].y)));
      end
      total++;
      if (bz !== 1'b0) begin bad++; $display("FAIL directed_%0d_busy_at_done got=%b want=0", i, bz); end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic res = 1'bx;
    @(negedge clk);
    a = WIDTH'(5); b = WIDTH'(7); op = 2'b00; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    a = WIDTH'(9); b = WIDTH'(2); op = 2'b00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b want=1", busy); end
    for (int c = 2; c <= N + 3; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = c; res = result; break; end
    end
    total++;
    if (res !== 1'b1) begin bad++; $display("FAIL ignore_result got=%b want=1", res); end
    total++;
    if (lat !== exp_lat(WIDTH'(5), WIDTH'(7))) begin
      bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, exp_lat(WIDTH'(5), WIDTH'(7)));
    end
  endtask

  task automatic test_back_to_back();
    int   c1 = -1, c2 = -1;
    logic r1 = 1'bx, r2 = 1'bx;
    @(negedge clk);
    a = WIDTH'(5); b = WIDTH'(7); op = 2'b00; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = {(WIDTH/8){8'hC3}}; b = {(WIDTH/8){8'hC3}}; op = 2'b10;
    for (int c = 1; c <= 2 * N + 6; c++) begin
      @(posedge clk); #1;
      if (c1 > 0 && c == c1 + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (c1 < 0) begin c1 = c; r1 = result; end
        else begin c2 = c; r2 = result; break; end
      end
    end
    start = 1'b0;
    total++; if (r1 !== 1'b1) begin bad++; $display("FAIL b2b_first_result got=%b want=1", r1); end
    total++; if (r2 !== 1'b1) begin bad++; $display("FAIL b2b_second_result got=%b want=1", r2); end
    total++;
    if (c1 !== exp_lat(WIDTH'(5), WIDTH'(7))) begin
      bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", c1, exp_lat(WIDTH'(5), WIDTH'(7)));
    end
    total++;
    if (c2 - c1 !== N + 1) begin
      bad++; $display("FAIL b2b_spacing got=%0d want=%0d", c2 - c1, N + 1);
    end
  endtask

  task automatic test_reset_abort();
    logic res, bz;
    int   lat, seen;
    issue(WIDTH'(3), WIDTH'(3), 2'b10, 1'b0, res, lat, bz);
    total++; if (res !== 1'b1) begin bad++; $display("FAIL abort_setup_result got=%b want=1", res); end
    @(negedge clk);
    a = '0; b = '0; op = 2'b10; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (result !== 1'b0) begin bad++; $display("FAIL abort_result got=%b want=0", result); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < N + 3; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    issue(WIDTH'(2), WIDTH'(9), 2'b01, 1'b0, res, lat, bz);
    total++; if (res !== 1'b1) begin bad++; $display("FAIL abort_recover_result got=%b want=1", res); end
    total++;
    if (lat !== exp_lat(WIDTH'(2), WIDTH'(9))) begin
      bad++; $display("FAIL abort_recover_latency got=%0d want=%0d", lat, exp_lat(WIDTH'(2), WIDTH'(9)));
    end
  endtask

  task automatic test_random(input int count);
    logic [WIDTH-1:0] x, y;
    logic [1:0]       o;
    logic             s, res, bz, want;
    int               lat, wl;
    for (int t = 0; t < count; t++) begin
      x = rand_word();
      case ($urandom_range(0, 3))
        0: y = rand_word();
        1: y = x;
        2: begin y = x; y[$urandom_range(0, WIDTH - 1)] ^= 1'b1; end
        default: begin y = x; y[WIDTH-1 -: 4] = 4'($urandom_range(0, 15)); end
      endcase
      o = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      want = ref_cmp(x, y, o, s);
      wl   = exp_lat(x, y);
      issue(x, y, o, s, res, lat, bz);
      total++;
      if (res !== want) begin
        bad++; $display("FAIL random_%0d_result a=%h b=%h op=%0d sgn=%b got=%b want=%b",
                        t, x, y, o, s, res, want);
      end
      total++;
      if (lat !== wl) begin
        bad++; $display("FAIL random_%0d_latency a=%h b=%h got=%0d want=%0d", t, x, y, lat, wl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits compared per cycle; WIDTH mod CHUNK SHALL be 0; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 a  input  WIDTH  first operand, sampled on accepting edge.
REQ-007 b  input  WIDTH  second operand, sampled on accepting edge.
REQ-008 op  input  2  00 LT (a<b), 01 LE (a<=b), 10 EQ, 11 NE; sampled on accepting edge.
REQ-009 sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accepting edge.
REQ-010 busy  output  1  high while compare in progress.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 result  output  1  compare outcome; held from done until next accepted start.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 SHALL capture operands, op and sgn, load chunk index N-1, and enter RUN. busy=1 from the next cycle.
REQ-015 When sgn=1, SHALL invert bit WIDTH-1 of both captured operands, so that unsigned chunk compare yields signed order.
REQ-016 RUN SHALL evaluate one CHUNK-bit slice per cycle, MSB slice first, index decrementing.
REQ-017 Per slice, SHALL latch first-difference flags: lt_found (a slice < b slice) or gt_found, set only while no difference has yet been recorded.
REQ-018 After slice 0, SHALL enter DONE: done=1, busy=0, result = LT: lt_found; LE: !gt_found; EQ: neither flag; NE: either flag.
REQ-019 Without early exit, done SHALL assert exactly N cycles after the accepting edge (N=8 at defaults); latency is operand-independent.
REQ-020 DONE SHALL last one cycle, then IDLE unless start=1, which SHALL be accepted (back-to-back issue, one compare per N+1 cycles).
REQ-021 start while busy=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-022 result SHALL update only on entry to DONE.
REQ-023 Operand changes after the accepting edge SHALL have no effect on the result.

Reset
REQ-024 rst_n low SHALL force IDLE, busy=0, done=0, result=0, flags and chunk index cleared, at any time including mid-RUN; the aborted compare produces no done.
REQ-025 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-026 Macro SERIAL_COMPARE_EARLY_EXIT_EN defined: RUN SHALL enter DONE at the edge where the first differing slice is evaluated; done arrives j cycles after accept, where j = 1-based index of that slice; equal operands still take N cycles.
REQ-027 Macro undefined: constant N-cycle latency per REQ-019; no early-exit logic synthesised.

Structure
REQ-028 Package compare_pkg SHALL hold the op encodings (OP_LT, OP_LE, OP_EQ, OP_NE) and the FSM state enum.
REQ-029 Sub-module compare_chunk (combinational, parameter CHUNK, outputs lt and eq for one slice) SHALL be instantiated once; serial_compare holds all sequential state.

Verification
REQ-030 Defaults, unsigned, op=LT, a=0x00000005, b=0x00000007 -> done at cycle 8 after accept, result=1; op=LE, a=b=0x7 -> result=1; op=LT, same operands -> result=0.
REQ-031 sgn=1, op=LT, a=0xFFFFFFFF (-1), b=0x00000001 -> result=1; sgn=0, same operands -> result=0.
REQ-032 op=EQ, a=b=0xDEADBEEF -> result=1; op=NE, a=0xDEADBEEF, b=0xDEADBEEE -> result=1; with SERIAL_COMPARE_EARLY_EXIT_EN, the latter -> done at cycle 8; a=0x10000000, b=0x00000000 -> done at cycle 1.
REQ-033 Start asserted during RUN with different operands -> ignored; result reflects the first operands. Start held high through DONE -> the second compare is accepted and its done arrives N+1 cycles after the first done.
REQ-034 rst_n pulsed low at cycle 3 of RUN -> busy, done and result are 0 immediately, with no done pulse afterwards; the next start completes normally.
REQ-035 Randomised a, b, op and sgn against a reference-model compare over 10k transactions, with and without the macro, for CHUNK values 1, 4 and 8.
